// File: rtl/fifo_rd_stream.sv
// Purpose: turns an async-FIFO read port (ren/rdata/rempty) into a registered valid/ready stream.
// Latency: a word popped from the FIFO appears on m_valid/m_data one cycle after fifo_ren.
// Backpressure: 2-entry head+skid buffer; fifo_ren depends only on state, so m_ready never reaches it.
module fifo_rd_stream #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  fifo_rempty,
    input  logic [DATA_WIDTH-1:0] fifo_rdata,
    output logic                  fifo_ren,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    input  logic                  m_ready,
    input  logic                  flush,
    output logic [1:0]            level,
    output logic [CNT_WIDTH-1:0]  xfer_count
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [DATA_WIDTH-1:0] r_head;
    logic [DATA_WIDTH-1:0] r_skid;
    logic [CNT_WIDTH-1:0]  r_cnt;

    logic w_push;
    logic w_pop;
    logic w_head_ld_fifo;
    logic w_head_ld_skid;
    logic w_skid_ld;

    // Pop request is built only from registered state and non-stream inputs.
    assign w_push   = ~fifo_rempty & (r_state != ST_TWO) & ~flush & ~reset;
    assign w_pop    = (r_state != ST_EMPTY) & m_ready;

    assign fifo_ren   = w_push;
    assign m_valid    = (r_state != ST_EMPTY);
    assign m_data     = r_head;
    assign level      = r_state;
    assign xfer_count = r_cnt;

    // Next-state and buffer load selects; flush empties the buffer regardless of traffic.
    always_comb begin
        w_state_nxt    = r_state;
        w_head_ld_fifo = 1'b0;
        w_head_ld_skid = 1'b0;
        w_skid_ld      = 1'b0;
        if (flush) begin
            w_state_nxt = ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_push) begin
                        w_state_nxt    = ST_ONE;
                        w_head_ld_fifo = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (w_push && !w_pop) begin
                        w_state_nxt = ST_TWO;
                        w_skid_ld   = 1'b1;
                    end else if (w_push && w_pop) begin
                        w_head_ld_fifo = 1'b1;
                    end else if (w_pop) begin
                        w_state_nxt = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    // No push can happen here, so a pop just promotes the skid word.
                    if (w_pop) begin
                        w_state_nxt    = ST_ONE;
                        w_head_ld_skid = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = ST_EMPTY;
                end
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Head and skid data registers; contents are don't-care while not counted by state.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_head <= '0;
            r_skid <= '0;
        end else begin
            if (w_head_ld_fifo) begin
                r_head <= fifo_rdata;
            end else if (w_head_ld_skid) begin
                r_head <= r_skid;
            end
            if (w_skid_ld) begin
                r_skid <= fifo_rdata;
            end
        end
    end

    // Handshake counter; a handshake in a flush cycle is a real delivery and still counts.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (w_pop) begin
            r_cnt <= r_cnt + CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Purpose: scoreboard bench for fifo_rd_stream with a queue-based FIFO model.
// Latency: checks every cycle against a small occupancy model (ren, valid, level, count, data).
// Backpressure: exercises m_ready stalls, toggling, flush, mid-stream reset and counter wrap.
module tb_fifo_rd_stream;

    localparam int DW = 8;
    localparam int CW = 16;

    logic          clk;
    logic          reset;
    logic          fifo_rempty;
    logic [DW-1:0] fifo_rdata;
    logic          fifo_ren;
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic          m_ready;
    logic          flush;
    logic [1:0]    level;
    logic [CW-1:0] xfer_count;

    fifo_rd_stream #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk         (clk),
        .reset       (reset),
        .fifo_rempty (fifo_rempty),
        .fifo_rdata  (fifo_rdata),
        .fifo_ren    (fifo_ren),
        .m_valid     (m_valid),
        .m_data      (m_data),
        .m_ready     (m_ready),
        .flush       (flush),
        .level       (level),
        .xfer_count  (xfer_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int n_chk  = 0;
    int n_fail = 0;
    int n_ren  = 0;

    logic [DW-1:0] fifo_q[$];   // FIFO model contents
    logic [DW-1:0] exp_q[$];    // words not yet delivered, in order (buffer + FIFO)
    int            m_lvl;       // model buffer occupancy
    logic [CW-1:0] m_cnt;       // model handshake count

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic push_word(input logic [DW-1:0] d);
        fifo_q.push_back(d);
        exp_q.push_back(d);
    endtask

    // One clock cycle: present FIFO pins, check outputs against the model, advance both.
    task automatic tick();
        logic ren_exp;
        logic pop_exp;
        int   drop;
        fifo_rempty = (fifo_q.size() == 0);
        fifo_rdata  = (fifo_q.size() != 0) ? fifo_q[0] : 8'h5A;
        #1;
        ren_exp = (fifo_q.size() != 0) && (m_lvl != 2) && !flush && !reset;
        pop_exp = (m_lvl != 0) && m_ready;
        chk("fifo_ren", {31'd0, fifo_ren}, {31'd0, ren_exp});
        chk("m_valid", {31'd0, m_valid}, {31'd0, (m_lvl != 0)});
        chk("level", {30'd0, level}, 32'(m_lvl));
        chk("xfer_count", {16'd0, xfer_count}, {16'd0, m_cnt});
        if (m_lvl != 0 && exp_q.size() != 0)
            chk("m_data", {24'd0, m_data}, {24'd0, exp_q[0]});
        if (fifo_ren) n_ren++;
        if (pop_exp) void'(exp_q.pop_front());
        if (reset || flush) begin
            drop = m_lvl - (pop_exp ? 1 : 0);
            if (reset) drop = m_lvl;
            repeat (drop) void'(exp_q.pop_front());
        end
        @(posedge clk);
        if (ren_exp) void'(fifo_q.pop_front());
        if (reset) begin
            m_lvl = 0;
            m_cnt = '0;
        end else begin
            if (flush) m_lvl = 0;
            else m_lvl = m_lvl + (ren_exp ? 1 : 0) - (pop_exp ? 1 : 0);
            if (pop_exp) m_cnt = m_cnt + 16'd1;
        end
        #1;
    endtask

    // Run with the current m_ready until every queued word is delivered.
    task automatic drain(input int budget);
        int cyc = 0;
        while ((exp_q.size() != 0 || m_lvl != 0) && cyc < budget) begin
            tick();
            cyc++;
        end
        chk("drain_timeout", 32'(cyc < budget), 32'd1);
    endtask

    initial begin
        logic [CW-1:0] cnt0;
        int guard;
        reset   = 1'b1;
        flush   = 1'b0;
        m_ready = 1'b0;
        m_lvl   = 0;
        m_cnt   = '0;
        push_word(8'h11);
        fifo_rempty = 1'b0;
        fifo_rdata  = 8'h11;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_m_valid", {31'd0, m_valid}, 32'd0);
        chk("rst_level", {30'd0, level}, 32'd0);
        chk("rst_m_data", {24'd0, m_data}, 32'd0);
        chk("rst_xfer", {16'd0, xfer_count}, 32'd0);
        chk("rst_ren", {31'd0, fifo_ren}, 32'd0);
        tick();
        reset = 1'b0;

        // Three words streamed with m_ready held high.
        push_word(8'h22);
        push_word(8'h33);
        m_ready = 1'b1;
        drain(20);
        chk("t1_xfer", {16'd0, xfer_count}, 32'd3);
        chk("t1_level", {30'd0, level}, 32'd0);

        // Stall with five words available: exactly two pops, head held.
        m_ready = 1'b0;
        n_ren   = 0;
        for (int i = 0; i < 5; i++) push_word(8'h40 + 8'(i));
        repeat (12) tick();
        chk("t2_ren_pulses", 32'(n_ren), 32'd2);
        chk("t2_level", {30'd0, level}, 32'd2);
        chk("t2_head", {24'd0, m_data}, 32'h40);
        m_ready = 1'b1;
        drain(30);
        chk("t2_xfer", {16'd0, xfer_count}, 32'd8);

        // Toggling m_ready against a continuous supply.
        for (int i = 0; i < 16; i++) push_word(8'(i));
        guard = 0;
        while ((exp_q.size() != 0 || m_lvl != 0) && guard < 100) begin
            m_ready = ~guard[0];
            tick();
            guard++;
        end
        chk("t3_timeout", 32'(guard < 100), 32'd1);
        chk("t3_xfer", {16'd0, xfer_count}, 32'd24);

        // Flush with two buffered words and a concurrent handshake.
        m_ready = 1'b0;
        push_word(8'hA0);
        push_word(8'hA1);
        push_word(8'hA2);
        repeat (4) tick();
        chk("t4_level_pre", {30'd0, level}, 32'd2);
        cnt0    = m_cnt;
        m_ready = 1'b1;
        flush   = 1'b1;
        tick();
        flush   = 1'b0;
        m_ready = 1'b0;
        chk("t4_xfer", {16'd0, xfer_count}, {16'd0, cnt0 + 16'd1});
        chk("t4_m_valid", {31'd0, m_valid}, 32'd0);
        chk("t4_level", {30'd0, level}, 32'd0);
        tick();
        chk("t4_after_head", {24'd0, m_data}, 32'hA2);
        m_ready = 1'b1;
        drain(20);

        // Mid-stream reset with two buffered words and count of seven.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 7; i++) push_word(8'h70 + 8'(i));
        m_ready = 1'b1;
        drain(30);
        m_ready = 1'b0;
        push_word(8'hB0);
        push_word(8'hB1);
        repeat (4) tick();
        chk("t6_level_pre", {30'd0, level}, 32'd2);
        chk("t6_xfer_pre", {16'd0, xfer_count}, 32'd7);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t6_m_valid", {31'd0, m_valid}, 32'd0);
        chk("t6_level", {30'd0, level}, 32'd0);
        chk("t6_xfer", {16'd0, xfer_count}, 32'd0);
        push_word(8'hC5);
        m_ready = 1'b1;
        drain(20);
        chk("t6_post_xfer", {16'd0, xfer_count}, 32'd1);

        // Counter wrap: reach 0xFFFF, then two more handshakes.
        reset = 1'b1;
        tick();
        reset   = 1'b0;
        m_ready = 1'b1;
        guard   = 0;
        while (m_cnt != 16'hFFFF && guard < 70000) begin
            if (fifo_q.size() < 3) push_word(8'(guard));
            tick();
            guard++;
        end
        chk("t5_pre_wrap", {16'd0, xfer_count}, 32'hFFFF);
        guard = 0;
        while (m_cnt != 16'd1 && guard < 20) begin
            if (fifo_q.size() < 3) push_word(8'(guard));
            tick();
            guard++;
        end
        chk("t5_wrap", {16'd0, xfer_count}, 32'd1);
        drain(20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
